// File: rtl/de_frame_pkg.sv
// -----------------------------------------------------------------------------
// de_frame_pkg
// Shared UART framing definitions used by the Rx de-framer and the Tx framer.
//   - default payload width and the frame-width derivation
//   - bit positions of start, data, parity and stop inside an assembled frame
//   - parity-mode encoding (even / odd)
// -----------------------------------------------------------------------------
package de_frame_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Frame layout, LSB first on the wire:
  //   [0]            start bit
  //   [DW:1]         payload, LSB at [1]
  //   [DW+1]         parity bit
  //   [DW+2]         stop bit
  localparam int START_IDX = 0;
  localparam int DATA_LSB  = 1;

  function automatic int frameWidth(input int dataWidth);
    return dataWidth + 3;
  endfunction

  function automatic int parityIdx(input int dataWidth);
    return dataWidth + 1;
  endfunction

  function automatic int stopIdx(input int dataWidth);
    return dataWidth + 2;
  endfunction

  // Positions for the default 8-bit payload.
  localparam int FRAME_W    = frameWidth(DATA_WIDTH_DEF);
  localparam int PARITY_IDX = parityIdx(DATA_WIDTH_DEF);
  localparam int STOP_IDX   = stopIdx(DATA_WIDTH_DEF);

  typedef enum logic {
    MODE_EVEN = 1'b0,
    MODE_ODD  = 1'b1
  } parityMode_e;

  // Maps an integer parity-select parameter onto the mode encoding.
  function automatic parityMode_e parityMode(input int oddSel);
    return (oddSel != 0) ? MODE_ODD : MODE_EVEN;
  endfunction

endpackage : de_frame_pkg

// File: rtl/de_frame_parity_calc.sv
// -----------------------------------------------------------------------------
// parity_calc
// Combinational parity generator shared by the Rx de-framer and Tx framer.
// Produces the parity bit a correct frame must carry for the given payload.
//   data    in   WIDTH  payload bits
//   mode    in   1      MODE_EVEN: XOR of data; MODE_ODD: inverted XOR
//   parity  out  1      expected parity bit
// -----------------------------------------------------------------------------
module parity_calc
  import de_frame_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  parityMode_e      mode,
  output logic             parity
);

  // Odd parity makes the total count of ones odd, so the even result flips.
  assign parity = (^data) ^ logic'(mode);

endmodule : parity_calc

// File: rtl/de_frame.sv
// -----------------------------------------------------------------------------
// de_frame
// UART receiver de-framing stage. Takes the fully assembled serial frame from
// the Rx shift/sample unit as a parallel word, splits it into its fields,
// checks parity and framing, and registers everything with a one-cycle
// completion strobe.
//   Clock         in   1        system clock, rising edge
//   Reset         in   1        asynchronous, active-high
//   RecievedFlag  in   1        DataParl valid qualifier (one capture per cycle)
//   DataParl      in   FRAME_W  assembled frame (start/data/parity/stop)
//   RawData       out  DW       extracted payload
//   StartBit      out  1        extracted start bit
//   ParityBit     out  1        extracted parity bit
//   StopBit       out  1        extracted stop bit
//   ParityError   out  1        received parity disagrees with computed parity
//   FrameError    out  1        start bit not 0 or stop bit not 1
//   DoneFlag      out  1        high for the cycle after each capture
// -----------------------------------------------------------------------------
module de_frame
  import de_frame_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int PARITY_ODD = 0,
  localparam int FRAME_W    = frameWidth(DATA_WIDTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RecievedFlag,
  input  logic [FRAME_W-1:0]    DataParl,
  output logic [DATA_WIDTH-1:0] RawData,
  output logic                  StartBit,
  output logic                  ParityBit,
  output logic                  StopBit,
  output logic                  ParityError,
  output logic                  FrameError,
  output logic                  DoneFlag
);

  localparam int          parityPos = parityIdx(DATA_WIDTH);
  localparam int          stopPos   = stopIdx(DATA_WIDTH);
  localparam parityMode_e modeSel   = parityMode(PARITY_ODD);

  logic [DATA_WIDTH-1:0] frameData;
  logic                  expectedParity;

  assign frameData = DataParl[DATA_LSB +: DATA_WIDTH];

  parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) parityGen (
    .data   (frameData),
    .mode   (modeSel),
    .parity (expectedParity)
  );

  // Errors are informational: fields load whether or not the frame is good.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // Idle line level: stop bit reads as 1 so a reset frame is not "broken".
      RawData     <= '0;
      StartBit    <= 1'b0;
      ParityBit   <= 1'b0;
      StopBit     <= 1'b1;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
      DoneFlag    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would create ordering-dependent races.
      DoneFlag <= RecievedFlag;
      // NOTE: no else branch on purpose -- inside always_ff the missing
      // branch means "hold", giving enabled flops rather than a latch. It also
      // keeps an unknown DataParl from reaching the outputs while idle.
      if (RecievedFlag) begin
        RawData     <= frameData;
        StartBit    <= DataParl[START_IDX];
        ParityBit   <= DataParl[parityPos];
        StopBit     <= DataParl[stopPos];
        ParityError <= expectedParity ^ DataParl[parityPos];
        FrameError  <= DataParl[START_IDX] | ~DataParl[stopPos];
      end
    end
  end

endmodule : de_frame

// File: tb/tb_de_frame.sv
// -----------------------------------------------------------------------------
// tb_de_frame
// Self-checking bench for de_frame. Two instances share the stimulus: one in
// even-parity mode, one in odd-parity mode. A reference model derives the
// expected fields from each captured word with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_de_frame;

  localparam int DW = 8;
  localparam int FW = DW + 3;

  logic          clk = 1'b0;
  logic          clkRun = 1'b0;
  logic          Reset;
  logic          RecievedFlag;
  logic [FW-1:0] DataParl;

  logic [DW-1:0] rawE, rawO;
  logic          startE, startO, parE, parO, stopE, stopO;
  logic          perrE, perrO, ferrE, ferrO, doneE, doneO;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: {data, start, parity, stop, parityErr, frameErr}
  logic [DW+4:0] modelE, modelO;
  logic          modelDone;

  always #5 if (clkRun) clk = ~clk;

  de_frame #(.DATA_WIDTH(DW), .PARITY_ODD(0)) dutEven (
    .Clock(clk), .Reset(Reset), .RecievedFlag(RecievedFlag), .DataParl(DataParl),
    .RawData(rawE), .StartBit(startE), .ParityBit(parE), .StopBit(stopE),
    .ParityError(perrE), .FrameError(ferrE), .DoneFlag(doneE)
  );

  de_frame #(.DATA_WIDTH(DW), .PARITY_ODD(1)) dutOdd (
    .Clock(clk), .Reset(Reset), .RecievedFlag(RecievedFlag), .DataParl(DataParl),
    .RawData(rawO), .StartBit(startO), .ParityBit(parO), .StopBit(stopO),
    .ParityError(perrO), .FrameError(ferrO), .DoneFlag(doneO)
  );

  wire [DW+5:0] obsE = {rawE, startE, parE, stopE, perrE, ferrE, doneE};
  wire [DW+5:0] obsO = {rawO, startO, parO, stopO, perrO, ferrO, doneO};

  // Reference: decode the frame word arithmetically.
  function automatic logic [DW+4:0] decode(input int unsigned word, input bit oddMode);
    int unsigned payload, startB, parityB, stopB, ones;
    bit expPar, perr, ferr;
    payload = (word / 2) % 256;
    startB  = word % 2;
    parityB = (word / 512) % 2;
    stopB   = (word / 1024) % 2;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += (payload >> i) & 1;
    expPar = ((ones % 2) == 1) != oddMode;
    perr   = expPar != (parityB == 1);
    ferr   = (startB != 0) || (stopB != 1);
    return {payload[DW-1:0], startB[0], parityB[0], stopB[0], perr, ferr};
  endfunction

  localparam logic [DW+4:0] RESET_FIELDS = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic void modelReset();
    modelE    = RESET_FIELDS;
    modelO    = RESET_FIELDS;
    modelDone = 1'b0;
  endfunction

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit flag, input logic [FW-1:0] word, input bit rst, input string name);
    @(negedge clk);
    Reset        = rst;
    RecievedFlag = flag;
    DataParl     = word;
    @(posedge clk);
    #1;
    if (rst) modelReset();
    else begin
      if (flag) begin
        modelE = decode(int'(word), 1'b0);
        modelO = decode(int'(word), 1'b1);
      end
      modelDone = flag;
    end
    vectors++;
    if (obsE !== {modelE, modelDone}) begin
      miscompares++;
      $display("FAIL %s even: got %h expected %h (word %h)", name, obsE, {modelE, modelDone}, word);
    end
    vectors++;
    if (obsO !== {modelO, modelDone}) begin
      miscompares++;
      $display("FAIL %s odd: got %h expected %h (word %h)", name, obsO, {modelO, modelDone}, word);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; RecievedFlag = 1'b0; DataParl = '0;
    #3;
    modelReset();
    vectors++;
    if (obsE !== {RESET_FIELDS, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_no_clock even: got %h expected %h", obsE, {RESET_FIELDS, 1'b0});
    end
    vectors++;
    if (obsO !== {RESET_FIELDS, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_no_clock odd: got %h expected %h", obsO, {RESET_FIELDS, 1'b0});
    end
    clkRun = 1'b1;
    cycle(1'b1, 11'h7FF, 1'b1, "reset_held");
    cycle(1'b0, 11'h000, 1'b0, "reset_release");
  endtask

  task automatic test_basic();
    cycle(1'b1, 11'h4AA, 1'b0, "basic_4AA");
    vectors++;
    if (rawE !== 8'h55 || perrE !== 1'b0 || ferrE !== 1'b0 || doneE !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_4AA_fields: got raw %h perr %b ferr %b done %b expected 55 0 0 1",
               rawE, perrE, ferrE, doneE);
    end
    cycle(1'b0, 11'h4AA, 1'b0, "basic_done_drop");
  endtask

  task automatic test_parity();
    cycle(1'b1, 11'h6AA, 1'b0, "parity_6AA");
    vectors++;
    if (perrE !== 1'b1 || perrO !== 1'b0 || parE !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_6AA_flags: got even perr %b odd perr %b parity %b expected 1 0 1",
               perrE, perrO, parE);
    end
    cycle(1'b0, 11'h000, 1'b0, "parity_idle");
  endtask

  task automatic test_all_ones();
    cycle(1'b1, 11'h7FF, 1'b0, "all_ones");
    vectors++;
    if ({rawE, startE, stopE, parE, ferrE, perrE} !== {8'hFF, 5'b11111}) begin
      miscompares++;
      $display("FAIL all_ones_fields: got %h expected %h",
               {rawE, startE, stopE, parE, ferrE, perrE}, {8'hFF, 5'b11111});
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 11'h4AA, 1'b0, "hold_capture");
    for (int i = 0; i < 10; i++) cycle(1'b0, FW'($urandom), 1'b0, "hold_random");
    cycle(1'b0, 'x, 1'b0, "hold_x_data");
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, FW'($urandom), 1'b0, "b2b_1");
    cycle(1'b1, FW'($urandom), 1'b0, "b2b_2");
    // Asynchronous reset between edges must act without a clock edge.
    #2;
    Reset = 1'b1;
    #1;
    modelReset();
    vectors++;
    if (obsE !== {RESET_FIELDS, 1'b0} || obsO !== {RESET_FIELDS, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_async_reset: got %h/%h expected %h",
               obsE, obsO, {RESET_FIELDS, 1'b0});
    end
    cycle(1'b1, 11'h7FF, 1'b1, "b2b_reset_override");
    cycle(1'b1, FW'($urandom), 1'b0, "b2b_resume");
    cycle(1'b1, FW'($urandom), 1'b0, "b2b_4");
    cycle(1'b1, FW'($urandom), 1'b0, "b2b_5");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), FW'($urandom), 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_all_ones();
    test_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_de_frame
